// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, lane masks.
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} lsu_state_e;

  // Size 11 is illegal and falls through to the word mask.
  function automatic logic [3:0] base_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: base_mask = 4'b0001;
      SZ_HALF: base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// Lane alignment: shifts store data/mask into lanes, shifts and extends load data.
module mem_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic        hi,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_word,
  input  logic [31:0] lo,
  output logic [3:0]  wren,
  output logic [31:0] wd,
  output logic [31:0] rd,
  output logic [31:0] lo_next,
  output logic        straddle
);
  logic [7:0]  mask8;
  logic [5:0]  lsh, rsh;
  logic [31:0] joined;

  assign lsh      = {1'b0, off, 3'b000};
  assign rsh      = {3'd4 - {1'b0, off}, 3'b000};
  assign mask8    = {4'b0000, base_mask(size)} << off;
  assign straddle = |mask8[7:4];

  assign wren    = hi ? mask8[7:4] : mask8[3:0];
  assign wd      = hi ? (wdata >> rsh) : (wdata << lsh);
  assign lo_next = rd_word >> lsh;
  // Second half: upper bytes of the result come from the next word's low lanes.
  assign joined  = hi ? (lo | (rd_word << rsh)) : lo_next;

  always_comb begin
    case (size)
      SZ_BYTE: rd = {{24{sext & joined[7]}}, joined[7:0]};
      SZ_HALF: rd = {{16{sext & joined[15]}}, joined[15:0]};
      default: rd = joined;
    endcase
  end
endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: byte/half/word accesses to a 4-lane memory, splitting word-straddling ones.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        stall,
  output logic        misalign,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wren,
  input  logic [31:0] mem_rdata
);
  lsu_state_e  state, nxt;
  logic [31:0] lo, lo_next, base, al_wd, al_rd;
  logic [3:0]  al_wren;
  logic        strad;

  assign base = {addr[31:2], 2'b00};

  mem_lane_align u_align (
    .off      (addr[1:0]),
    .size     (size),
    .sext     (sext),
    .hi       (state == SECOND),
    .wdata    (wdata),
    .rd_word  (mem_rdata),
    .lo       (lo),
    .wren     (al_wren),
    .wd       (al_wd),
    .rd       (al_rd),
    .lo_next  (lo_next),
    .straddle (strad)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lo    <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == SECOND) lo <= lo_next;
    end
  end

  always_comb begin
    nxt       = state;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = '0;
    rdata     = '0;
    done      = 1'b0;
    stall     = 1'b0;
    misalign  = 1'b0;
    if (!rst) begin
      if (state == SECOND) begin
        // Finishes with whatever inputs are present, even if req dropped.
        mem_addr  = base + 32'd4;
        mem_wdata = al_wd;
        mem_wren  = we ? al_wren : 4'b0000;
        rdata     = al_rd;
        done      = 1'b1;
        nxt       = IDLE;
      end else if (req) begin
        if (strad && !SPLIT_EN) begin
          misalign = 1'b1;
          done     = 1'b1;
        end else begin
          mem_addr  = base;
          mem_wdata = al_wd;
          mem_wren  = we ? al_wren : 4'b0000;
          if (strad) begin
            stall = 1'b1;
            nxt   = SECOND;
          end else begin
            done  = 1'b1;
            rdata = al_rd;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed vector table, split/reset sequences, random ops vs byte-level model.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst, req, we, sext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        done, stall, misalign;
  logic [3:0]  mem_wren;
  logic [31:0] rdata_ns, mem_addr_ns, mem_wdata_ns, mem_rdata_ns;
  logic        done_ns, stall_ns, misalign_ns;
  logic [3:0]  mem_wren_ns;

  logic [31:0] tmem [1024];
  logic [7:0]  rmem [4096];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  mem_lsu #(.SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .stall(stall),
    .misalign(misalign), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .mem_rdata(mem_rdata));

  mem_lsu #(.SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .rdata(rdata_ns), .done(done_ns), .stall(stall_ns),
    .misalign(misalign_ns), .mem_addr(mem_addr_ns), .mem_wdata(mem_wdata_ns),
    .mem_wren(mem_wren_ns), .mem_rdata(mem_rdata_ns));

  assign mem_rdata    = tmem[mem_addr[11:2]];
  assign mem_rdata_ns = tmem[mem_addr_ns[11:2]];

  always @(posedge clk)
    for (int k = 0; k < 4; k++)
      if (mem_wren[k]) tmem[mem_addr[11:2]][8*k +: 8] <= mem_wdata[8*k +: 8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sx);
    logic [31:0] v = '0;
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) v[8*i +: 8] = rmem[(a + i) & 32'hFFF];
    if (n == 1 && sx && v[7])  v[31:8]  = '1;
    if (n == 2 && sx && v[15]) v[31:16] = '1;
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    for (int i = 0; i < nbytes(sz); i++) rmem[(a + i) & 32'hFFF] = d[8*i +: 8];
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    tmem[a[11:2]] = d;
    for (int i = 0; i < 4; i++) rmem[(a + i) & 32'hFFF] = d[8*i +: 8];
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = d;
  endtask

  typedef struct {
    logic w; logic [1:0] sz; logic sx; logic [31:0] a; logic [31:0] d;
    logic [3:0] e_wren; logic [31:0] e_addr; logic [31:0] e_wd; logic [31:0] e_rd; bit chk_rd;
  } vec_t;

  initial begin
    vec_t vt [11];
    for (int i = 0; i < 1024; i++) tmem[i] = '0;
    for (int i = 0; i < 4096; i++) rmem[i] = '0;
    vt[0]  = '{1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 4'hF, 32'h100, 32'hDEADBEEF, 0, 0};
    vt[1]  = '{0, 2'b10, 0, 32'h100, 32'h0,        4'h0, 32'h100, 0, 32'hDEADBEEF, 1};
    vt[2]  = '{1, 2'b00, 0, 32'h203, 32'h000000A5, 4'h8, 32'h200, 32'hA5000000, 0, 0};
    vt[3]  = '{0, 2'b00, 1, 32'h203, 32'h0,        4'h0, 32'h200, 0, 32'hFFFFFFA5, 1};
    vt[4]  = '{0, 2'b00, 0, 32'h203, 32'h0,        4'h0, 32'h200, 0, 32'h000000A5, 1};
    vt[5]  = '{1, 2'b01, 0, 32'h102, 32'h0000CAFE, 4'hC, 32'h100, 32'hCAFE0000, 0, 0};
    vt[6]  = '{0, 2'b01, 1, 32'h102, 32'h0,        4'h0, 32'h100, 0, 32'hFFFFCAFE, 1};
    vt[7]  = '{0, 2'b01, 0, 32'h102, 32'h0,        4'h0, 32'h100, 0, 32'h0000CAFE, 1};
    vt[8]  = '{0, 2'b00, 1, 32'h101, 32'h0,        4'h0, 32'h100, 0, 32'hFFFFFFBE, 1};
    vt[9]  = '{1, 2'b11, 0, 32'h104, 32'h01020304, 4'hF, 32'h104, 32'h01020304, 0, 0};
    vt[10] = '{0, 2'b10, 1, 32'h104, 32'h0,        4'h0, 32'h104, 0, 32'h01020304, 1};

    // Reset: outputs quiet even with a store request present.
    rst = 1'b1; req = 0; we = 0; size = 0; sext = 0; addr = 0; wdata = 0;
    step();
    drive(1, 2'b10, 0, 32'h100, 32'hDEADBEEF);
    #2;
    chk("rst_wren", {28'd0, mem_wren}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_wdata", mem_wdata, 0);
    step();
    rst = 1'b0; req = 1'b0;
    #2;
    chk("idle_done", {31'd0, done}, 0);
    chk("idle_wren", {28'd0, mem_wren}, 0);
    step();

    foreach (vt[i]) begin
      drive(vt[i].w, vt[i].sz, vt[i].sx, vt[i].a, vt[i].d);
      #2;
      chk($sformatf("v%0d_done", i), {31'd0, done}, 1);
      chk($sformatf("v%0d_stall", i), {31'd0, stall}, 0);
      chk($sformatf("v%0d_wren", i), {28'd0, mem_wren}, {28'd0, vt[i].e_wren});
      chk($sformatf("v%0d_addr", i), mem_addr, vt[i].e_addr);
      if (vt[i].w) chk($sformatf("v%0d_wdata", i), mem_wdata, vt[i].e_wd);
      if (vt[i].chk_rd) chk($sformatf("v%0d_rdata", i), rdata, vt[i].e_rd);
      step();
      if (vt[i].w) ref_store(vt[i].a, vt[i].sz, vt[i].d);
      req = 1'b0;
    end

    // Split half store across 0x300/0x304.
    drive(1, 2'b01, 0, 32'h303, 32'h00001234);
    #2;
    chk("sh_c1_wren", {28'd0, mem_wren}, 32'h8);
    chk("sh_c1_addr", mem_addr, 32'h300);
    chk("sh_c1_byte", {24'd0, mem_wdata[31:24]}, 32'h34);
    chk("sh_c1_stall", {31'd0, stall}, 1);
    chk("sh_c1_done", {31'd0, done}, 0);
    step();
    chk("sh_c2_wren", {28'd0, mem_wren}, 32'h1);
    chk("sh_c2_addr", mem_addr, 32'h304);
    chk("sh_c2_byte", {24'd0, mem_wdata[7:0]}, 32'h12);
    chk("sh_c2_done", {31'd0, done}, 1);
    chk("sh_c2_stall", {31'd0, stall}, 0);
    step();
    ref_store(32'h303, 2'b01, 32'h1234);
    drive(0, 2'b01, 1, 32'h303, 0);
    step();
    chk("lh_split_rdata", rdata, 32'h00001234);
    chk("lh_split_done", {31'd0, done}, 1);
    step();
    req = 1'b0;

    // Split word load.
    preload(32'h400, 32'h44332211);
    preload(32'h404, 32'h88776655);
    drive(0, 2'b10, 0, 32'h401, 0);
    #2;
    chk("lw_c1_stall", {31'd0, stall}, 1);
    step();
    chk("lw_c2_rdata", rdata, 32'h55443322);
    chk("lw_c2_stall", {31'd0, stall}, 0);
    step();
    req = 1'b0;

    // Top-of-address-space wrap, and the non-splitting variant.
    drive(1, 2'b10, 0, 32'hFFFFFFFE, 32'hAABBCCDD);
    #2;
    chk("wrap_c1_addr", mem_addr, 32'hFFFFFFFC);
    chk("wrap_c1_wren", {28'd0, mem_wren}, 32'hC);
    chk("ns_misalign", {31'd0, misalign_ns}, 1);
    chk("ns_wren", {28'd0, mem_wren_ns}, 0);
    chk("ns_done", {31'd0, done_ns}, 1);
    chk("ns_stall", {31'd0, stall_ns}, 0);
    chk("ns_rdata", rdata_ns, 0);
    step();
    chk("wrap_c2_addr", mem_addr, 32'h0);
    chk("wrap_c2_wren", {28'd0, mem_wren}, 32'h3);
    chk("wrap_c2_wdata", mem_wdata, 32'h0000AABB);
    step();
    ref_store(32'hFFFFFFFE, 2'b10, 32'hAABBCCDD);
    req = 1'b0;

    // Reset during SECOND: only the first-half lanes land.
    preload(32'h500, 0);
    preload(32'h504, 0);
    drive(1, 2'b10, 0, 32'h502, 32'h11223344);
    step();
    rst = 1'b1;
    #2;
    chk("rst2_wren", {28'd0, mem_wren}, 0);
    chk("rst2_done", {31'd0, done}, 0);
    step();
    rst = 1'b0;
    rmem[12'h502] = 8'h44;
    rmem[12'h503] = 8'h33;
    drive(0, 2'b10, 0, 32'h504, 0);
    #2;
    chk("rst2_idle_done", {31'd0, done}, 1);
    chk("rst2_idle_stall", {31'd0, stall}, 0);
    chk("rst2_hi_word", rdata, 32'h0);
    step();
    drive(0, 2'b10, 0, 32'h500, 0);
    #2;
    chk("rst2_lo_word", rdata, 32'h33440000);
    step();
    req = 1'b0;

    // Random ops against the byte-level model.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, d, exp_rd;
      logic [1:0] sz;
      logic w, sx, got;
      int cyc, exp_cyc;
      bit strad;
      a = $urandom_range(0, 4095);
      d = $urandom;
      sz = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      sx = 1'($urandom_range(0, 1));
      strad = (int'(a[1:0]) + nbytes(sz)) > 4;
      exp_cyc = strad ? 2 : 1;
      exp_rd = ref_load(a, sz, sx);
      drive(w, sz, sx, a, d);
      cyc = 0; got = 1'b0;
      repeat (3) if (!got) begin
        #2;
        cyc++;
        if (cyc == 1) chk("rnd_ns_misalign", {31'd0, misalign_ns}, {31'd0, strad});
        if (done === 1'b1) begin
          got = 1'b1;
          if (!w) chk($sformatf("rnd%0d_rdata a=%h sz=%0d", n, a, sz), rdata, exp_rd);
        end
        step();
      end
      chk("rnd_done", {31'd0, got}, 1);
      chk($sformatf("rnd%0d_cycles", n), cyc, exp_cyc);
      if (w) ref_store(a, sz, d);
      req = 1'b0;
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit between the single-cycle core's execute stage and the 4-lane byte-addressed data memory. Converts byte/half/word load and store requests into lane write-enables, lane-shifted write data and aligned, sign- or zero-extended load results. Accesses that straddle a 32-bit word boundary are split into two memory cycles by a small state machine that stalls the core for one cycle.

## Interface
- SPLIT_EN, 1, 1: split misaligned straddling accesses; 0: flag them via `misalign` and suppress the access.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  1  access request from core; held stable by core while `stall`=1.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word; 11 is illegal, treated as word.
- sext  in  1  loads only: 1 sign-extend, 0 zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified.
- rdata  out  32  load result, extended, valid when `done`=1 and `we`=0.
- done  out  1  access completes this cycle.
- stall  out  1  core must hold PC and request this cycle.
- misalign  out  1  straddling access with SPLIT_EN=0; no memory effect.
- mem_addr  out  32  word address to memory; only bits [17:2] used downstream.
- mem_wdata  out  32  lane-positioned write data.
- mem_wren  out  4  per-lane write enable, lane0 = bits [7:0].
- mem_rdata  in  32  combinational read data from memory.

## Operation
- Little-endian; byte offset off = addr[1:0]; lane k holds byte at word address + k.
- Base mask: byte 0001, half 0011, word 1111. Straddle when (mask << off) exceeds 4 bits.
- States: IDLE, SECOND.
- IDLE, req=1, no straddle: mem_addr = {addr[31:2],2'b00}; mem_wren = (mask<<off) if we else 0; mem_wdata = wdata << 8*off; rdata = extend(mem_rdata >> 8*off); done=1, stall=0; stay IDLE.
- IDLE, req=1, straddle, SPLIT_EN=1: first half — low word, mem_wren = low 4 bits of (mask<<off); loads capture mem_rdata >> 8*off into hold register `lo`; stall=1, done=0; go SECOND.
- SECOND: mem_addr = {addr[31:2],2'b00} + 4 (32-bit wrap: 0xFFFFFFFC+4 = 0); mem_wren = (mask<<off)>>4; mem_wdata = wdata >> 8*(4-off); rdata = extend of bytes from `lo` (low 4-off bytes) concatenated with mem_rdata low bytes; done=1, stall=0; return IDLE.
- Straddle with SPLIT_EN=0: misalign=1, done=1, mem_wren=0, rdata=0, stall=0.
- Extension uses the MSB of the loaded byte/half; word ignores sext.
- req=0 in IDLE: mem_wren=0, done=0, stall=0, rdata=0.

## Timing
- Reset values: state IDLE, lo=0; while rst=1 all outputs 0 (mem_wren=0 regardless of req).
- Aligned access: 0-cycle latency; load result combinational from mem_rdata same cycle; store commits at the closing clock edge.
- Split access: 2 cycles; first-half store lanes commit at end of cycle 1, second-half at end of cycle 2.
- Reset asserted in SECOND: returns IDLE next edge; first-half store already committed stays committed (documented partial write); second half suppressed.
- req deasserted in SECOND is a core protocol violation; unit still completes SECOND using current inputs.
- No back-to-back restriction: new request accepted in the cycle after done.

## Structure
- Shared package `lsu_pkg`: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, base-mask function.
- One combinational sub-module `mem_lane_align`: offset shift for write data/mask and right-shift plus extension for read data; instantiated once, FSM selects shift amounts.

## Test plan
- sw addr 0x100, wdata 0xDEADBEEF -> mem_wren 1111, mem_addr 0x100, done=1 same cycle; lw 0x100 returns 0xDEADBEEF.
- sb addr 0x203, wdata 0x000000A5 -> mem_wren 1000, mem_wdata[31:24]=0xA5; lb sext=1 returns 0xFFFFFFA5, lbu returns 0x000000A5.
- sh addr 0x303, wdata 0x1234 -> cycle1 wren 1000 at 0x300 (0x34), stall=1; cycle2 wren 0001 at 0x304 (0x12), done=1; lh 0x303 returns 0x00001234.
- lw addr 0x401 with words 0x400=0x44332211, 0x404=0x88776655 -> stall 1 cycle, rdata 0x55443322.
- sw addr 0xFFFFFFFE -> second access mem_addr 0x00000000, wren 0011; SPLIT_EN=0 variant -> misalign=1, mem_wren=0.
- rst asserted during SECOND of split sw -> next cycle state IDLE, mem_wren 0, only first-half lanes changed.
